// File: rtl/car_sensor_gen_pkg.sv
// Shared encodings for the car sensor emulator: FSM states, {a,b} patterns, direction codes.
package car_sensor_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PH1     = 3'd1,
    ST_PH2     = 3'd2,
    ST_PH3     = 3'd3,
    ST_TAIL    = 3'd4,
    ST_RETREAT = 3'd5
  } state_e;

  localparam logic [1:0] AB_IDLE  = 2'b00;
  localparam logic [1:0] AB_OUTER = 2'b10;
  localparam logic [1:0] AB_BOTH  = 2'b11;
  localparam logic [1:0] AB_INNER = 2'b01;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  // Pattern shown in advancing phase 1..3; phase 0 means both beams clear.
  function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] ph);
    logic [1:0] ab;
    ab = AB_IDLE;
    case (ph)
      2'd1:    ab = (dir == DIR_EXIT) ? AB_INNER : AB_OUTER;
      2'd2:    ab = AB_BOTH;
      2'd3:    ab = (dir == DIR_EXIT) ? AB_OUTER : AB_INNER;
      default: ab = AB_IDLE;
    endcase
    return ab;
  endfunction

  function automatic logic [1:0] state_phase(input state_e s);
    logic [1:0] ph;
    ph = 2'd0;
    case (s)
      ST_PH1:  ph = 2'd1;
      ST_PH2:  ph = 2'd2;
      ST_PH3:  ph = 2'd3;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/car_sensor_gen_if.sv
// Request/response bundle between a sequence requester and the car sensor emulator.
interface car_sensor_gen_if #(
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 4
);
   logic              start;
   logic              dir;
   logic [HOLD_W-1:0] hold;
   logic              abort;
   logic              a;
   logic              b;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [CNT_W-1:0]  exp_count;

   modport master (
      output start, dir, hold, abort,
      input  a, b, busy, done, aborted, exp_count
   );

   modport slave (
      input  start, dir, hold, abort,
      output a, b, busy, done, aborted, exp_count
   );
endinterface

// File: rtl/car_sensor_gen_hold_timer.sv
// Per-phase down-counter: loads H-1 on phase entry, expires at zero and holds there.
module hold_timer
   import car_sensor_gen_pkg::*;
#(
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic [HOLD_W-1:0] value_i,
   output logic              expire_o,
   output logic              nxt_zero_o
);

   logic [HOLD_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o   = (cnt_q == '0);
   // Lets the parent register a pulse that lines up with the final cycle of a phase.
   assign nxt_zero_o = (cnt_d == '0);

endmodule

// File: rtl/car_sensor_gen.sv
// Emulates the two photo-sensors of a car entering or exiting, with back-out support
// and the occupancy value a downstream counter is expected to show.
module car_sensor_gen
   import car_sensor_gen_pkg::*;
#(
   parameter int HOLD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   car_sensor_gen_if.slave bus
);

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic              dir_q, dir_d;
   logic [HOLD_W-1:0] hm1_q, hm1_d;
   logic [1:0]        ab_q, ab_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              tmr_load;
   logic [HOLD_W-1:0] tmr_val;
   logic              tmr_expire;
   logic              tmr_nxt_zero;
   logic [HOLD_W-1:0] hold_m1;

   // A zero hold is stretched to one cycle per phase.
   assign hold_m1 = (bus.hold == '0) ? '0 : (bus.hold - 1'b1);

   hold_timer #(.HOLD_W(HOLD_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .value_i    (tmr_val),
      .expire_o   (tmr_expire),
      .nxt_zero_o (tmr_nxt_zero)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      dir_d    = dir_q;
      hm1_d    = hm1_q;
      cnt_d    = cnt_q;
      tmr_load = 1'b0;
      tmr_val  = hm1_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_PH1;
               dir_d    = bus.dir;
               hm1_d    = hold_m1;
               tmr_load = 1'b1;
               tmr_val  = hold_m1;
            end
         end
         ST_PH1, ST_PH2, ST_PH3: begin
            if (bus.abort) begin
               state_d  = ST_RETREAT;
               idx_d    = state_phase(state_q);
               tmr_load = 1'b1;
            end else if (tmr_expire) begin
               tmr_load = 1'b1;
               case (state_q)
                  ST_PH1:  state_d = ST_PH2;
                  ST_PH2:  state_d = ST_PH3;
                  default: state_d = ST_TAIL;
               endcase
            end
         end
         ST_TAIL: begin
            if (tmr_expire) begin
               state_d = ST_IDLE;
               cnt_d   = (dir_q == DIR_EXIT) ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
            end
         end
         ST_RETREAT: begin
            // idx 1 is the single all-clear cycle that closes a back-out.
            if (idx_q == 2'd1) begin
               state_d = ST_IDLE;
            end else if (tmr_expire) begin
               idx_d    = idx_q - 2'd1;
               tmr_load = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_comb begin
      ab_d = AB_IDLE;
      case (state_d)
         ST_PH1:     ab_d = phase_ab(dir_d, 2'd1);
         ST_PH2:     ab_d = phase_ab(dir_d, 2'd2);
         ST_PH3:     ab_d = phase_ab(dir_d, 2'd3);
         ST_RETREAT: ab_d = phase_ab(dir_d, idx_d - 2'd1);
         default:    ab_d = AB_IDLE;
      endcase
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_TAIL) && tmr_nxt_zero;
      aborted_d = (state_d == ST_RETREAT) && (idx_d == 2'd1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= 2'd0;
         dir_q     <= DIR_ENTER;
         hm1_q     <= '0;
         ab_q      <= AB_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         dir_q     <= dir_d;
         hm1_q     <= hm1_d;
         ab_q      <= ab_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.a         = ab_q[1];
   assign bus.b         = ab_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.aborted   = aborted_q;
   assign bus.exp_count = cnt_q;

endmodule
